pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/pipe_ctrl_int_edge_latch.sv | 37 +++
 rtl/pipe_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared processor control constants: FSM state encoding, memory push source
// codes and PC mux select codes, also used by the memory and PC-mux stages.
package pipe_ctrl_pkg;

    // Interrupt-entry FSM state encoding.
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_DRAIN      = 3'd1;
    localparam logic [2:0] ST_PUSH_PC    = 3'd2;
    localparam logic [2:0] ST_PUSH_FLAGS = 3'd3;
    localparam logic [2:0] ST_VECTOR     = 3'd4;

    // Memory push source codes.
    localparam logic [1:0] PUSH_NONE  = 2'b00;
    localparam logic [1:0] PUSH_PC    = 2'b01;
    localparam logic [1:0] PUSH_FLAGS = 2'b10;

    // PC mux select codes.
    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_VECTOR = 2'b11;

    // Bundle of every control output, so one default clears them all.
    typedef struct packed {
        logic       stall_if;
        logic       flush_id;
        logic       flush_ex;
        logic [1:0] push_sel;
        logic [1:0] pc_sel;
        logic       int_ack;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/interrupt inputs and pipeline control outputs of the pipeline
// controller. master = the controller, slave = the pipeline side.
interface pipe_ctrl_if;
    logic       HDU_stall_in;
    logic       branch_taken_EX_in;
    logic       int_in;
    logic       stall_IF_out;
    logic       flush_ID_out;
    logic       flush_EX_out;
    logic [1:0] push_sel_out;
    logic [1:0] pc_sel_out;
    logic       int_ack_out;
    logic       busy_out;

    modport master (
        input  HDU_stall_in, branch_taken_EX_in, int_in,
        output stall_IF_out, flush_ID_out, flush_EX_out,
               push_sel_out, pc_sel_out, int_ack_out, busy_out
    );

    modport slave (
        output HDU_stall_in, branch_taken_EX_in, int_in,
        input  stall_IF_out, flush_ID_out, flush_EX_out,
               push_sel_out, pc_sel_out, int_ack_out, busy_out
    );
endinterface

// File: rtl/pipe_ctrl_int_edge_latch.sv
// Interrupt rising-edge detector and pending latch. A request is merged into
// an already pending one until service starts; an edge that arrives while a
// service is in progress is queued and re-arms pending when VECTOR clears it.
module int_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic int_in,
    input  logic in_service,
    input  logic clear,
    output logic pending
);
    logic int_q;
    logic queued;
    logic rise;

    assign rise = int_in & ~int_q;

    // Register int_in, latch rising edges, clear pending in the VECTOR cycle.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            int_q   <= 1'b0;
            pending <= 1'b0;
            queued  <= 1'b0;
        end else begin
            int_q <= int_in;
            if (clear) begin
                pending <= queued | rise;
                queued  <= 1'b0;
            end else if (rise) begin
                if (in_service) queued  <= 1'b1;
                else            pending <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: branch flush, load-use stall and a multi-cycle
// interrupt entry sequence (drain, push PC, push flags, vector).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int         DRAIN_CYCLES   = 2,
    parameter logic [1:0] INT_VECTOR_SEL = PC_SEL_VECTOR
) (
    input logic         clk,
    input logic         reset,
    pipe_ctrl_if.master bus
);
    logic [2:0] state;
    logic [2:0] next_state;
    logic [1:0] drain_cnt;
    logic       int_pending;
    logic       in_service;
    logic       clear_pending;
    ctrl_t      ctrl;

    assign in_service    = (state == ST_DRAIN) || (state == ST_PUSH_PC) ||
                           (state == ST_PUSH_FLAGS);
    assign clear_pending = (state == ST_VECTOR);

    int_edge_latch u_int_edge_latch (
        .clk        (clk),
        .reset      (reset),
        .int_in     (bus.int_in),
        .in_service (in_service),
        .clear      (clear_pending),
        .pending    (int_pending)
    );

    // Next-state logic; hazards only gate interrupt entry while in IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        next_state = state;
        case (state)
            ST_IDLE:
                if (int_pending && !bus.HDU_stall_in && !bus.branch_taken_EX_in)
                    next_state = ST_DRAIN;
            ST_DRAIN:
                if (drain_cnt == 2'd0) next_state = ST_PUSH_PC;
            ST_PUSH_PC:    next_state = ST_PUSH_FLAGS;
            ST_PUSH_FLAGS: next_state = ST_VECTOR;
            ST_VECTOR:     next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
    end

    // State register and drain counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            drain_cnt <= 2'd0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && next_state == ST_DRAIN)
                drain_cnt <= 2'(DRAIN_CYCLES - 1);
            else if (state == ST_DRAIN && drain_cnt != 2'd0)
                drain_cnt <= drain_cnt - 2'd1;
        end
    end

    // Output decode; IDLE outputs follow the hazard inputs with no latency.
    always_comb begin
        ctrl = CTRL_NONE;
        case (state)
            ST_IDLE: begin
                if (bus.branch_taken_EX_in) begin
                    ctrl.flush_id = 1'b1;
                    ctrl.flush_ex = 1'b1;
                end else if (bus.HDU_stall_in) begin
                    ctrl.stall_if = 1'b1;
                    ctrl.flush_ex = 1'b1;
                end
            end
            ST_DRAIN: begin
                ctrl.stall_if = 1'b1;
                ctrl.flush_id = 1'b1;
            end
            ST_PUSH_PC: begin
                ctrl.stall_if = 1'b1;
                ctrl.flush_id = 1'b1;
                ctrl.push_sel = PUSH_PC;
            end
            ST_PUSH_FLAGS: begin
                ctrl.stall_if = 1'b1;
                ctrl.flush_id = 1'b1;
                ctrl.push_sel = PUSH_FLAGS;
            end
            ST_VECTOR: begin
                ctrl.flush_id = 1'b1;
                ctrl.pc_sel   = INT_VECTOR_SEL;
                ctrl.int_ack  = 1'b1;
            end
            default: ctrl = CTRL_NONE;
        endcase
        // Hold every output low while reset is asserted.
        if (reset) ctrl = CTRL_NONE;
    end

    assign bus.stall_IF_out = ctrl.stall_if;
    assign bus.flush_ID_out = ctrl.flush_id;
    assign bus.flush_EX_out = ctrl.flush_ex;
    assign bus.push_sel_out = ctrl.push_sel;
    assign bus.pc_sel_out   = ctrl.pc_sel;
    assign bus.int_ack_out  = ctrl.int_ack;
    assign bus.busy_out     = (state != ST_IDLE) && !reset;

endmodule
